// File: rtl/fifo_read_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl_pkg
// Brief    : Gray/binary pointer helpers shared by both sides of the async FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_read_ctrl_pkg;

    // Both conversions are width-agnostic as long as unused upper bits are zero,
    // so callers zero-extend into 32 bits and truncate the result back.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for Gray pointers crossing clock domains.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Nothing may sit between the two flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl
// Brief    : Async FIFO read-side pointer/empty logic with a registered
//            valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [ADDR_SIZE:0]   wptr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic [ADDR_SIZE-1:0] raddr,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 rempty,
    output logic                 ralmost_empty,
    output logic [ADDR_SIZE:0]   rlevel
);

    localparam int c_PTR_W = ADDR_SIZE + 1;

    logic [c_PTR_W-1:0]   r_rbin;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W-1:0]   r_rlevel;
    logic                 r_rempty;
    logic                 r_ralmost_empty;
    logic [DATA_SIZE-1:0] r_dout;
    logic                 r_dout_valid;

    logic [c_PTR_W-1:0]   w_rq2_wptr;
    logic [c_PTR_W-1:0]   w_wbin_sync;
    logic [c_PTR_W-1:0]   w_rbinnext;
    logic [c_PTR_W-1:0]   w_rgraynext;
    logic [c_PTR_W-1:0]   w_level;
    logic                 w_pop;

    sync_2ff #(
        .WIDTH (c_PTR_W)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr),
        .q     (w_rq2_wptr)
    );

    // A word leaves memory whenever the output register is free or being drained.
    assign w_pop       = !r_rempty && (!r_dout_valid || dout_ready);
    assign w_rbinnext  = r_rbin + c_PTR_W'(w_pop);
    assign w_rgraynext = c_PTR_W'(bin2gray(32'(w_rbinnext)));
    assign w_wbin_sync = c_PTR_W'(gray2bin(32'(w_rq2_wptr)));
    assign w_level     = w_wbin_sync - w_rbinnext;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_rbin          <= '0;
            r_rptr          <= '0;
            r_rempty        <= 1'b1;
            r_ralmost_empty <= 1'b1;
            r_rlevel        <= '0;
        end else begin
            r_rbin          <= w_rbinnext;
            r_rptr          <= w_rgraynext;
            r_rempty        <= (w_rgraynext == w_rq2_wptr);
            r_ralmost_empty <= (w_level <= c_PTR_W'(AE_THRESH));
            r_rlevel        <= w_level;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_pop) begin
            r_dout       <= rdata;
            r_dout_valid <= 1'b1;
        end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign rptr          = r_rptr;
    assign raddr         = r_rbin[ADDR_SIZE-1:0];
    assign dout          = r_dout;
    assign dout_valid    = r_dout_valid;
    assign rempty        = r_rempty;
    assign ralmost_empty = r_ralmost_empty;
    assign rlevel        = r_rlevel;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_ctrl
// Brief    : Self-checking bench for fifo_read_ctrl against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic [4:0] wptr = '0;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic [7:0] rdata;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rlevel;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int n_pass = 0;
    int n_total = 0;
    int wr_cnt = 0;
    int cons = 0;
    int beats = 0;

    always #5 rclk = ~rclk;

    assign rdata = mem[raddr];

    fifo_read_ctrl #(
        .DATA_SIZE (8),
        .ADDR_SIZE (4),
        .AE_THRESH (2)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .wptr          (wptr),
        .rptr          (rptr),
        .raddr         (raddr),
        .rdata         (rdata),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel)
    );

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = 5'(b % 32);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock edge plus the model update and the rules that hold on every cycle.
    task automatic step();
        logic       pv, pr, prst;
        logic [7:0] pd;
        int         mem_unread;
        pv = dout_valid; pr = dout_ready; prst = rrst_n; pd = dout;
        @(posedge rclk);
        #1;
        if (!prst) begin
            cons = 0;
            exp_q.delete();
            for (int i = 0; i < wr_cnt; i++) exp_q.push_back(mem[i % 16]);
        end else if (pv && pr) begin
            if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
            else chk("beat_data", {24'd0, pd}, {24'd0, exp_q.pop_front()});
            cons++;
            beats++;
        end else if (pv) begin
            chk("hold_data", {24'd0, dout}, {24'd0, pd});
            chk("hold_valid", {31'd0, dout_valid}, 32'd1);
        end
        mem_unread = exp_q.size() - int'(dout_valid);
        chk("raddr", {28'd0, raddr}, 32'((cons + int'(dout_valid)) % 16));
        chk("rptr", {27'd0, rptr}, {27'd0, gray5(cons + int'(dout_valid))});
        chk("rlevel_bound", {31'd0, (int'(rlevel) <= mem_unread)}, 32'd1);
        chk("ae_vs_level", {31'd0, ralmost_empty}, {31'd0, (rlevel <= 5'd2)});
        if (!rempty) chk("rempty_safe", {31'd0, (mem_unread > 0)}, 32'd1);
    endtask

    task automatic do_reset(input int n, input int edges);
        wr_cnt = n;
        wptr   = gray5(n);
        rrst_n = 1'b0;
        repeat (edges) step();
        rrst_n = 1'b1;
    endtask

    task automatic write_words(input int n, input int base, input bit rnd);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'(base + i);
            mem[wr_cnt % 16] = d;
            exp_q.push_back(d);
            wr_cnt++;
        end
        wptr = gray5(wr_cnt);
    endtask

    task automatic drain(input bit rnd);
        int t = 0;
        while ((exp_q.size() != 0 || dout_valid) && t < 300) begin
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            t++;
        end
        dout_ready = 1'b0;
        chk("drain_done", exp_q.size(), 32'd0);
    endtask

    initial begin
        int t;
        // T1: reset with a pending write pointer
        mem[0] = 8'hA5;
        do_reset(1, 2);
        chk("t1_rempty", {31'd0, rempty}, 32'd1);
        chk("t1_valid", {31'd0, dout_valid}, 32'd0);
        chk("t1_rptr", {27'd0, rptr}, 32'd0);
        chk("t1_raddr", {28'd0, raddr}, 32'd0);
        chk("t1_rlevel", {27'd0, rlevel}, 32'd0);
        chk("t1_ae", {31'd0, ralmost_empty}, 32'd1);

        // T2: single word, consumer stalled
        step(); chk("t2_empty_e1", {31'd0, rempty}, 32'd1);
        step(); chk("t2_empty_e2", {31'd0, rempty}, 32'd1);
        step(); chk("t2_empty_fall", {31'd0, rempty}, 32'd0);
        chk("t2_level", {27'd0, rlevel}, 32'd1);
        step();
        chk("t2_dout", {24'd0, dout}, 32'hA5);
        chk("t2_valid", {31'd0, dout_valid}, 32'd1);
        chk("t2_rptr", {27'd0, rptr}, 32'd1);
        chk("t2_rempty", {31'd0, rempty}, 32'd1);
        repeat (10) step();
        chk("t2_dout_held", {24'd0, dout}, 32'hA5);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        chk("t2_valid_drop", {31'd0, dout_valid}, 32'd0);

        // T3: full memory streamed with ready held high
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        dout_ready = 1'b1;
        do_reset(16, 1);
        t = 0;
        while (rempty && t < 8) begin step(); t++; end
        chk("t3_empty_latency", t, 32'd3);
        chk("t3_level_full", {27'd0, rlevel}, 32'd16);
        chk("t3_ae_full", {31'd0, ralmost_empty}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("t3_valid", {31'd0, dout_valid}, 32'd1);
            chk("t3_dout", {24'd0, dout}, 32'(k));
            chk("t3_level", {27'd0, rlevel}, 32'(15 - k));
            chk("t3_ae", {31'd0, ralmost_empty}, {31'd0, ((15 - k) <= 2)});
        end
        chk("t3_rptr_end", {27'd0, rptr}, 32'h18);
        chk("t3_rempty_end", {31'd0, rempty}, 32'd1);
        step();
        chk("t3_valid_end", {31'd0, dout_valid}, 32'd0);
        dout_ready = 1'b0;

        // T5: three words after the pointer wrap
        write_words(3, 8'hB0, 1'b0);
        chk("t5_wptr", {27'd0, wptr}, 32'h1A);
        step(); step(); step();
        chk("t5_rempty", {31'd0, rempty}, 32'd0);
        chk("t5_level", {27'd0, rlevel}, 32'd3);
        chk("t5_ae", {31'd0, ralmost_empty}, 32'd0);
        step();
        chk("t5_first", {24'd0, dout}, 32'hB0);
        drain(1'b0);
        chk("t5_rptr_end", {27'd0, rptr}, 32'h1A);

        // T4: sixteen words with ready toggling every cycle
        beats = 0;
        write_words(16, 0, 1'b0);
        t = 0;
        while ((exp_q.size() != 0 || dout_valid) && t < 100) begin
            dout_ready = ~dout_ready;
            step();
            t++;
        end
        dout_ready = 1'b0;
        chk("t4_beats", beats, 32'd16);

        // T6: reset in the middle of a stream
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        dout_ready = 1'b1;
        do_reset(16, 1);
        repeat (5) step();
        chk("t6_valid_pre", {31'd0, dout_valid}, 32'd1);
        do_reset(16, 1);
        chk("t6_valid", {31'd0, dout_valid}, 32'd0);
        chk("t6_dout", {24'd0, dout}, 32'd0);
        chk("t6_rptr", {27'd0, rptr}, 32'd0);
        chk("t6_rempty", {31'd0, rempty}, 32'd1);
        step(); chk("t6_empty_e1", {31'd0, rempty}, 32'd1);
        step(); chk("t6_empty_e2", {31'd0, rempty}, 32'd1);
        step(); chk("t6_empty_fall", {31'd0, rempty}, 32'd0);
        drain(1'b1);

        // Random writes and back-pressure
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0 && exp_q.size() < 16)
                write_words($urandom_range(1, 16 - exp_q.size()), 0, 1'b1);
            dout_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
